// File: rtl/ct_ifu_bht_pre_ctrl.sv
// Access controller in front of the single-port 1024x64 BHT prediction array.
// Arbitrates predictor reads against buffered counter updates and runs array initialization.
module ct_ifu_bht_pre_ctrl (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        cp0_ifu_bht_en,
  input  logic        cp0_ifu_bht_inv,
  output logic        ifu_cp0_bht_inv_done,
  input  logic        ifu_bht_rd_vld,
  input  logic [9:0]  ifu_bht_rd_index,
  output logic        bht_rd_grant,
  output logic        bht_rd_data_vld,
  input  logic        bju_bht_upd_vld,
  input  logic [9:0]  bju_bht_upd_index,
  input  logic [4:0]  bju_bht_upd_sel,
  input  logic [1:0]  bju_bht_upd_cnt,
  output logic        bht_upd_rdy,
  output logic        bht_pre_array_clk_en,
  output logic        bht_pred_array_cen_b,
  output logic        bht_pred_array_gwen,
  output logic [63:0] bht_pred_bwen,
  output logic [9:0]  bht_pred_array_index,
  output logic [63:0] bht_pred_array_din
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  localparam logic [63:0] INIT_PATTERN = 64'h5555_5555_5555_5555;
  localparam logic [63:0] ALL_ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  // Update entry layout: {index[16:7], sel[6:2], cnt[1:0]}
  function automatic logic [63:0] upd_din(input logic [1:0] cnt);
    upd_din = {32{cnt}};
  endfunction

  function automatic logic [63:0] upd_bwen(input logic [4:0] sel);
    upd_bwen = ~(64'h0000_0000_0000_0003 << {sel, 1'b0});
  endfunction

  state_t      state_q, state_d;
  logic [9:0]  init_cnt_q, init_cnt_d;
  logic        inv_done_q, inv_done_d;
  logic        rd_data_vld_q, rd_data_vld_d;
  logic [16:0] ent0_q, ent0_d;
  logic [16:0] ent1_q, ent1_d;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [9:0]  init_row_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        active_s;
  logic        rd_grant_s;
  logic        wr_s;
  logic        push_s;
  logic        flush_s;
  logic [16:0] new_ent_s;

  // Request qualification and one-access-per-cycle arbitration
  always_comb begin
    fifo_full_s  = (fifo_cnt_q == 2'd2);
    fifo_empty_s = (fifo_cnt_q == 2'd0);
    active_s     = (state_q == ST_IDLE) && cp0_ifu_bht_en;
    rd_grant_s   = active_s && ifu_bht_rd_vld && !fifo_full_s;
    wr_s         = active_s && (fifo_full_s || (!ifu_bht_rd_vld && !fifo_empty_s));
    push_s       = active_s && bju_bht_upd_vld && !fifo_full_s;
    flush_s      = (state_q != ST_IDLE) || !cp0_ifu_bht_en || cp0_ifu_bht_inv;
    new_ent_s    = {bju_bht_upd_index, bju_bht_upd_sel, bju_bht_upd_cnt};
    // An invalidate mid-init rewrites row 0 in the same cycle
    init_row_s   = cp0_ifu_bht_inv ? 10'd0 : init_cnt_q;
  end

  // FSM next state and init row counter
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    inv_done_d = 1'b0;
    case (state_q)
      ST_RST: begin
        state_d    = ST_INIT;
        init_cnt_d = 10'd0;
      end
      ST_INIT: begin
        init_cnt_d = init_row_s + 10'd1;
        if (init_row_s == 10'd1023) begin
          state_d    = ST_IDLE;
          inv_done_d = 1'b1;
        end else begin
          state_d    = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (cp0_ifu_bht_inv) begin
          state_d    = ST_INIT;
          init_cnt_d = 10'd0;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      default: begin
        state_d    = ST_RST;
        init_cnt_d = 10'd0;
      end
    endcase
  end

  // Two-entry update buffer; entry 0 is the head
  always_comb begin
    ent0_d     = ent0_q;
    ent1_d     = ent1_q;
    fifo_cnt_d = fifo_cnt_q;
    if (flush_s) begin
      fifo_cnt_d = 2'd0;
    end else begin
      case ({push_s, wr_s})
        2'b01: begin
          ent0_d     = ent1_q;
          fifo_cnt_d = fifo_cnt_q - 2'd1;
        end
        2'b10: begin
          if (fifo_empty_s) begin
            ent0_d = new_ent_s;
          end else begin
            ent1_d = new_ent_s;
          end
          fifo_cnt_d = fifo_cnt_q + 2'd1;
        end
        2'b11: begin
          if (fifo_cnt_q == 2'd1) begin
            ent0_d = new_ent_s;
          end else begin
            ent0_d = ent1_q;
            ent1_d = new_ent_s;
          end
        end
        default: begin
          fifo_cnt_d = fifo_cnt_q;
        end
      endcase
    end
    rd_data_vld_d = rd_grant_s;
  end

  // Array control drive
  always_comb begin
    bht_pred_array_cen_b = 1'b1;
    bht_pred_array_gwen  = 1'b1;
    bht_pred_bwen        = ALL_ONES;
    bht_pred_array_index = 10'd0;
    bht_pred_array_din   = 64'd0;
    if (state_q == ST_INIT) begin
      bht_pred_array_cen_b = 1'b0;
      bht_pred_array_gwen  = 1'b0;
      bht_pred_bwen        = 64'd0;
      bht_pred_array_index = init_row_s;
      bht_pred_array_din   = INIT_PATTERN;
    end else if (wr_s) begin
      bht_pred_array_cen_b = 1'b0;
      bht_pred_array_gwen  = 1'b0;
      bht_pred_bwen        = upd_bwen(ent0_q[6:2]);
      bht_pred_array_index = ent0_q[16:7];
      bht_pred_array_din   = upd_din(ent0_q[1:0]);
    end else if (rd_grant_s) begin
      bht_pred_array_cen_b = 1'b0;
      bht_pred_array_index = ifu_bht_rd_index;
    end else begin
      bht_pred_array_cen_b = 1'b1;
    end
    bht_pre_array_clk_en = !bht_pred_array_cen_b;
    bht_rd_grant         = rd_grant_s;
    bht_upd_rdy          = !fifo_full_s;
    bht_rd_data_vld      = rd_data_vld_q;
    ifu_cp0_bht_inv_done = inv_done_q;
  end

  // State registers
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q       <= ST_RST;
      init_cnt_q    <= 10'd0;
      inv_done_q    <= 1'b0;
      rd_data_vld_q <= 1'b0;
      ent0_q        <= 17'd0;
      ent1_q        <= 17'd0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      inv_done_q    <= inv_done_d;
      rd_data_vld_q <= rd_data_vld_d;
      ent0_q        <= ent0_d;
      ent1_q        <= ent1_d;
      fifo_cnt_q    <= fifo_cnt_d;
    end
  end

endmodule
